// File: rtl/uart_rx_gen.sv
// uart_rx_gen: oversampling UART receiver with configurable framing, parity,
// frame counting and sticky inactivity timeout. Define UART_RX_BREAK_EN to add break_det.
module uart_rx_gen #(
  parameter int unsigned CLKS_PER_BIT = 9,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned NUM_PACKETS  = 256,
  parameter int unsigned TIMEOUT_CLKS = 131072
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           rx,
  output logic                           tx,
  output logic                           data_valid,
  output logic [DATA_BITS-1:0]           data,
  output logic                           parity_err,
  output logic                           frame_err,
  output logic [$clog2(NUM_PACKETS)-1:0] packet_count,
  output logic                           buffer_finish,
  output logic                           timeout
`ifdef UART_RX_BREAK_EN
  ,
  output logic                           break_det
`endif
);

  localparam int unsigned PW     = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW     = $clog2(NUM_PACKETS);
  localparam int unsigned TW     = $clog2(TIMEOUT_CLKS) + 1;
  localparam int unsigned BW     = $clog2(DATA_BITS + 1);
  localparam int unsigned SAMPLE = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    S_WAIT_FIRST,
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t r_state, w_state_nxt;

  logic                 r_sync1, r_sync2;
  logic                 w_rx_s, w_edge, w_fall, w_fall_ok;
  logic [PW-1:0]        r_phase;
  logic                 w_sample;
  logic [BW-1:0]        r_bitcnt;
  logic                 w_last_data, w_last_stop;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_ferr_acc;
  logic                 r_from_wait;
  logic [TW-1:0]        r_tcnt;
  logic                 w_enter_start, w_enter_idle;

  logic                 w_done, w_par_x, w_perr, w_ferr, w_bfin;
  logic                 r_data_valid, r_perr, r_ferr, r_bfin, r_timeout;
  logic [DATA_BITS-1:0] r_data;
  logic [CW-1:0]        r_count;

  assign w_rx_s = r_sync2;
  assign w_edge = r_sync1 ^ r_sync2;
  assign w_fall = w_edge & ~r_sync1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Phase restarts on every line transition so sampling tracks the transmitter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      r_phase <= '0;
    else if (w_edge || r_phase == PW'(CLKS_PER_BIT - 1))
      r_phase <= '0;
    else
      r_phase <= r_phase + PW'(1);
  end

  assign w_sample    = (r_phase == PW'(SAMPLE));
  assign w_last_data = w_sample && (r_bitcnt == BW'(DATA_BITS - 1));
  assign w_last_stop = w_sample && (r_bitcnt == BW'(STOP_BITS - 1));

`ifdef UART_RX_BREAK_EN
  localparam int unsigned FRAME_CLKS =
    (1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS) * CLKS_PER_BIT;
  localparam int unsigned LW = $clog2(2 * FRAME_CLKS + 1);
  localparam int unsigned HW = $clog2(CLKS_PER_BIT + 1);

  logic [LW-1:0] r_low_cnt;
  logic [HW-1:0] r_high_cnt;
  logic          r_brk_hold, r_break_det, w_break;

  assign w_break   = ~w_rx_s && (r_low_cnt == LW'(2 * FRAME_CLKS - 1)) && (r_state != S_TIMEOUT);
  assign w_fall_ok = w_fall & ~r_brk_hold;
  assign break_det = r_break_det;

  // After a break, start detection stays blocked until one full bit of idle-high.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_low_cnt   <= '0;
      r_high_cnt  <= '0;
      r_brk_hold  <= 1'b0;
      r_break_det <= 1'b0;
    end else begin
      if (w_rx_s)
        r_low_cnt <= '0;
      else if (r_low_cnt != LW'(2 * FRAME_CLKS))
        r_low_cnt <= r_low_cnt + LW'(1);
      if (!w_rx_s)
        r_high_cnt <= '0;
      else if (r_high_cnt != HW'(CLKS_PER_BIT))
        r_high_cnt <= r_high_cnt + HW'(1);
      if (w_break)
        r_brk_hold <= 1'b1;
      else if (r_high_cnt == HW'(CLKS_PER_BIT))
        r_brk_hold <= 1'b0;
      r_break_det <= w_break;
    end
  end
`else
  assign w_fall_ok = w_fall;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      r_state <= S_WAIT_FIRST;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_FIRST: if (w_fall_ok) w_state_nxt = S_START;
      S_IDLE: begin
        if (w_fall_ok)
          w_state_nxt = S_START;
        else if (r_tcnt == TW'(TIMEOUT_CLKS - 1))
          w_state_nxt = S_TIMEOUT;
      end
      S_START: begin
        if (w_sample) begin
          if (!w_rx_s)
            w_state_nxt = S_DATA;
          else
            w_state_nxt = r_from_wait ? S_WAIT_FIRST : S_IDLE;
        end
      end
      S_DATA:   if (w_last_data) w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_sample) w_state_nxt = S_STOP;
      S_STOP:   if (w_last_stop) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = w_fall_ok ? S_START : S_IDLE;
      S_TIMEOUT: w_state_nxt = S_TIMEOUT;
      default:  w_state_nxt = S_WAIT_FIRST;
    endcase
`ifdef UART_RX_BREAK_EN
    if (w_break && (r_state == S_START || r_state == S_DATA ||
                    r_state == S_PARITY || r_state == S_STOP))
      w_state_nxt = S_IDLE;
`endif
  end

  always_comb begin
    w_done  = (w_state_nxt == S_DONE);
    w_par_x = (^r_shift) ^ r_par_bit;
    w_perr  = 1'b0;
    if (PARITY == 1)
      w_perr = ~w_par_x;
    else if (PARITY == 2)
      w_perr = w_par_x;
    // The final stop sample lands on the same cycle DONE is entered.
    w_ferr = r_ferr_acc | (w_sample & ~w_rx_s);
    w_bfin = w_done && (r_count == CW'(NUM_PACKETS - 1));
  end

  assign w_enter_start = (w_state_nxt == S_START) && (r_state != S_START);
  assign w_enter_idle  = (w_state_nxt == S_IDLE) && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_par_bit   <= 1'b0;
      r_ferr_acc  <= 1'b0;
      r_from_wait <= 1'b1;
      r_tcnt      <= '0;
    end else begin
      if (w_state_nxt != r_state)
        r_bitcnt <= '0;
      else if (w_sample && (r_state == S_DATA || r_state == S_STOP))
        r_bitcnt <= r_bitcnt + BW'(1);

      if (r_state == S_DATA && w_sample)
        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      if (r_state == S_PARITY && w_sample)
        r_par_bit <= w_rx_s;

      if (w_enter_start)
        r_ferr_acc <= 1'b0;
      else if (r_state == S_STOP && w_sample && !w_rx_s)
        r_ferr_acc <= 1'b1;

      if (w_enter_start)
        r_from_wait <= (r_state == S_WAIT_FIRST);

      if (w_enter_idle)
        r_tcnt <= '0;
      else if (r_state == S_IDLE)
        r_tcnt <= r_tcnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_data_valid <= 1'b0;
      r_bfin       <= 1'b0;
      r_data       <= '0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_count      <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_data_valid <= w_done;
      r_bfin       <= w_bfin;
      if (w_done) begin
        r_data  <= r_shift;
        r_perr  <= w_perr;
        r_ferr  <= w_ferr;
        r_count <= r_count + CW'(1);
      end
      if (w_state_nxt == S_TIMEOUT)
        r_timeout <= 1'b1;
    end
  end

  assign tx            = 1'b1;
  assign data_valid    = r_data_valid;
  assign data          = r_data;
  assign parity_err    = r_perr;
  assign frame_err     = r_ferr;
  assign packet_count  = r_count;
  assign buffer_finish = r_bfin;
  assign timeout       = r_timeout;

endmodule
